complete_arbiter: RTL and testbench
===================================

COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 Parameter NUM_FU, default 8: number of functional-unit completion requesters; index 7 = branch unit, index 0 = alu_1.
REQ-002 Parameter CDB_W, default 3: number of CDB write-back slots per cycle.
REQ-003 Parameter STARVE_MAX, default 3: consecutive denied cycles after which a requester becomes urgent.
REQ-004 clock  input  1  system clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fu_req  input  8  bit i = 1 means FU i holds a finished result this cycle.
REQ-007 squash  input  1  precise-state recovery (mispredict); kills all arbitration this cycle.
REQ-008 fu_grant  output  8  combinational; bit i = 1 means FU i wins a CDB slot this cycle.
REQ-009 fu_stall  output  8  combinational; equals fu_req & ~fu_grant, forced to 0 during squash.
REQ-010 slot_sel  output  3x4  registered; FU index driving CDB slot [2],[1],[0] next cycle; 4'hF = empty.
REQ-011 slot_valid  output  3  registered; slot_valid[k] = (slot_sel[k] != 4'hF).
REQ-012 stall_cycles  output  16  registered; count of cycles with fu_stall != 0.

Function
REQ-013 No request is granted when squash = 1; fu_grant and fu_stall are all-zero that cycle.
REQ-014 Urgent set SHALL be the requesters with fu_req[i] = 1 and starve_cnt[i] == STARVE_MAX.
REQ-015 Slots SHALL be filled first from the urgent set in ascending index order, then from the remaining requesters in round-robin order starting at rr_ptr and wrapping 7 -> 0.
REQ-016 At most CDB_W grants per cycle; fu_grant is one-hot per filled slot; no FU is granted twice.
REQ-017 Slot order: the first granted FU goes to slot 2, the second to slot 1, the third to slot 0; unfilled slots are 4'hF.
REQ-018 slot_sel and slot_valid SHALL update on the posedge after the grant (latency 1 cycle); a squash cycle loads all slots empty.
REQ-019 rr_ptr (3 bits) SHALL become (index of last non-urgent FU granted + 1) mod 8 when any non-urgent grant occurs; otherwise it holds.
REQ-020 starve_cnt[i] (2 bits) SHALL saturate-increment when fu_req[i] & ~fu_grant[i] & ~squash; otherwise it clears to 0.
REQ-021 squash SHALL clear all starve_cnt; rr_ptr holds.
REQ-022 stall_cycles SHALL saturate at 16'hFFFF and not wrap.
REQ-023 When at most CDB_W requests are present, every request is granted and fu_stall = 0.
REQ-024 When more than CDB_W requesters are urgent, the lowest three urgent indices are granted, and the rest keep starve_cnt = STARVE_MAX.
REQ-025 fu_grant SHALL depend only on current fu_req, squash and registered state, with no combinational loop.

Reset
REQ-026 On reset: slot_sel = {4'hF,4'hF,4'hF}, slot_valid = 0, rr_ptr = 0, all starve_cnt = 0, stall_cycles = 0.
REQ-027 Reset asserted mid-operation SHALL override squash and requests; state equals the REQ-026 values after that edge.
REQ-028 During the reset cycle, the combinational fu_grant is don't-care; fu_stall SHALL be 0.

Verification
REQ-029 Case 1: fu_req=8'b0000_0101, rr_ptr=0 -> grant 8'b0000_0101; next cycle slot_sel={0,2,F}, slot_valid=3'b110; rr_ptr=3.
REQ-030 Case 2: fu_req=8'hFF held for 4 cycles from reset -> grants 0x07, 0x38, 0xC1, then 0x0E; stall_cycles=4; no starve_cnt exceeds 3.
REQ-031 Case 3: set rr_ptr=6 and fu_req=8'b1100_0001 -> grant order 6,7,0 (wrap); slot_sel={6,7,0}; rr_ptr=1.
REQ-032 Case 4: FU 3 is denied for 3 consecutive cycles and then fu_req=8'hFF -> FU 3 is urgent and takes slot 2; the remaining two slots follow rr order.
REQ-033 Case 5: squash=1 with fu_req=8'hFF -> fu_grant=0, fu_stall=0; next cycle slot_valid=0 and all starve_cnt=0.
REQ-034 Case 6: reset asserted in the same cycle as fu_req=8'hFF and squash=0 -> after the edge, every state value equals REQ-026.

Source files
------------

// File: rtl/complete_arbiter.sv
// complete_arbiter
//   Chooses which finished functional units may write back on the CDB
//   each cycle. Requesters starved for STARVE_MAX consecutive cycles are
//   served first (ascending index); the remaining slots are filled in
//   round-robin order from rr_q. The chosen FU indices are registered
//   per CDB slot for the following cycle.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high reset
//   fu_req       : bit i set when FU i holds a finished result
//   squash       : mispredict recovery, suppresses all grants this cycle
//   fu_grant     : combinational, FU i wins a CDB slot this cycle
//   fu_stall     : combinational, fu_req & ~fu_grant (0 on squash/reset)
//   slot_sel     : registered FU index per CDB slot, 4'hF = empty
//   slot_valid   : registered, slot_sel[k] != 4'hF
//   stall_cycles : registered saturating count of cycles with any stall
module complete_arbiter #(
    parameter int unsigned NUM_FU     = 8,
    parameter int unsigned CDB_W      = 3,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FU-1:0]     fu_req,
    input  logic                  squash,
    output logic [NUM_FU-1:0]     fu_grant,
    output logic [NUM_FU-1:0]     fu_stall,
    output logic [CDB_W-1:0][3:0] slot_sel,
    output logic [CDB_W-1:0]      slot_valid,
    output logic [15:0]           stall_cycles
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [3:0]  EMPTY = 4'hF;

    logic [PTR_W-1:0]         rr_q, rr_d;
    logic [NUM_FU-1:0][1:0]   starve_q, starve_d;
    logic [CDB_W-1:0][3:0]    slot_q, slot_d, slot_pick;
    logic [CDB_W-1:0]         valid_q, valid_d;
    logic [15:0]              stall_q, stall_d;

    logic [NUM_FU-1:0]        urgent;
    logic [NUM_FU-1:0]        grant_raw;
    logic                     any_nu;
    logic [PTR_W-1:0]         last_nu;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            urgent[i] = fu_req[i] && (starve_q[i] == 2'(STARVE_MAX));
        end
    end

    // Slot filling: urgent pass first, then a rotated scan from rr_q that
    // skips urgent requesters (already considered). The n-th grant lands
    // in slot CDB_W-1-n so the first winner occupies the top slot.
    always_comb begin
        int unsigned filled;
        int unsigned idx;
        grant_raw = '0;
        slot_pick = '1;
        any_nu    = 1'b0;
        last_nu   = '0;
        filled    = 0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (urgent[i] && (filled < CDB_W)) begin
                grant_raw[i]                = 1'b1;
                slot_pick[CDB_W-1-filled]   = 4'(i);
                filled                      = filled + 1;
            end
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = k + rr_q;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (fu_req[idx] && !urgent[idx] && (filled < CDB_W)) begin
                grant_raw[idx]              = 1'b1;
                slot_pick[CDB_W-1-filled]   = 4'(idx);
                filled                      = filled + 1;
                any_nu                      = 1'b1;
                last_nu                     = PTR_W'(idx);
            end
        end
    end

    assign fu_grant = squash ? '0 : grant_raw;
    assign fu_stall = (squash || reset) ? '0 : (fu_req & ~grant_raw);

    always_comb begin
        rr_d    = rr_q;
        slot_d  = squash ? '1 : slot_pick;
        valid_d = '0;
        stall_d = stall_q;

        if (any_nu && !squash) begin
            rr_d = (last_nu == PTR_W'(NUM_FU - 1)) ? '0 : last_nu + 1'b1;
        end

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_req[i] && !fu_grant[i] && !squash) begin
                starve_d[i] = (starve_q[i] == 2'(STARVE_MAX)) ? starve_q[i]
                                                              : starve_q[i] + 2'd1;
            end else begin
                starve_d[i] = 2'd0;
            end
        end

        for (int unsigned s = 0; s < CDB_W; s++) begin
            valid_d[s] = (slot_d[s] != EMPTY);
        end

        if ((|fu_stall) && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q     <= '0;
            starve_q <= '0;
            slot_q   <= '1;
            valid_q  <= '0;
            stall_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    assign slot_sel     = slot_q;
    assign slot_valid   = valid_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter
//   Drives two arbiters with identical stimulus: one with default
//   parameters and one with STARVE_MAX = 1 so the urgent path is reached.
//   A queue-based reference model predicts grants, slots and counters.
module tb_complete_arbiter;

    logic           clock  = 1'b0;
    logic           reset  = 1'b1;
    logic           squash = 1'b0;
    logic [7:0]     fu_req = '0;

    logic [7:0]     grant0, stall0, grant1, stall1;
    logic [2:0][3:0] sel0, sel1;
    logic [2:0]     valid0, valid1;
    logic [15:0]    cyc0, cyc1;

    int n_tests = 0;
    int n_fail  = 0;

    int m_starve [2][8];
    int m_rr     [2];
    int m_stall  [2];

    always #5 clock = ~clock;

    complete_arbiter #(.NUM_FU(8), .CDB_W(3), .STARVE_MAX(3)) u_dut (
        .clock(clock), .reset(reset), .fu_req(fu_req), .squash(squash),
        .fu_grant(grant0), .fu_stall(stall0), .slot_sel(sel0),
        .slot_valid(valid0), .stall_cycles(cyc0)
    );

    complete_arbiter #(.NUM_FU(8), .CDB_W(3), .STARVE_MAX(1)) u_dut_fast (
        .clock(clock), .reset(reset), .fu_req(fu_req), .squash(squash),
        .fu_grant(grant1), .fu_stall(stall1), .slot_sel(sel1),
        .slot_valid(valid1), .stall_cycles(cyc1)
    );

    function automatic int smax(input int m);
        return (m == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Candidates: urgent ones ascending, then non-urgent in rotated order.
    // The first three candidates win, in slot order 2,1,0.
    function automatic void model_arb(input int m, input logic [7:0] req, input logic sq,
                                      output logic [7:0] g, output logic [11:0] sel,
                                      output int nrr);
        int order[$];
        int nurg;
        int idx;
        g   = '0;
        sel = '1;
        nrr = m_rr[m];
        if (sq) return;
        nurg = 0;
        for (int i = 0; i < 8; i++) begin
            if (req[i] && m_starve[m][i] == smax(m)) begin
                order.push_back(i);
                nurg++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            idx = (m_rr[m] + k) % 8;
            if (req[idx] && m_starve[m][idx] != smax(m)) order.push_back(idx);
        end
        for (int j = 0; j < order.size() && j < 3; j++) begin
            g[order[j]] = 1'b1;
            sel[(2-j)*4 +: 4] = 4'(order[j]);
            if (j >= nurg) nrr = (order[j] + 1) % 8;
        end
    endfunction

    task automatic step(input logic [7:0] req, input logic sq, input logic rst,
                        input logic [8:0] dg);
        logic [7:0]  eg  [2];
        logic [11:0] es  [2];
        logic [2:0]  ev  [2];
        int          nrr [2];
        logic [7:0]  og  [2];
        logic [7:0]  ost [2];
        logic [11:0] osel[2];
        logic [2:0]  ov  [2];
        logic [15:0] oc  [2];
        logic [7:0]  denied;

        fu_req = req;
        squash = sq;
        reset  = rst;
        #1;
        og[0] = grant0; ost[0] = stall0;
        og[1] = grant1; ost[1] = stall1;
        for (int m = 0; m < 2; m++) begin
            model_arb(m, req, sq, eg[m], es[m], nrr[m]);
            if (!rst) chk($sformatf("grant_u%0d", m), og[m], eg[m]);
            chk($sformatf("stall_u%0d", m), ost[m], (rst || sq) ? 8'h00 : (req & ~eg[m]));
        end
        if (dg[8]) chk("grant_directed", grant0, dg[7:0]);

        @(posedge clock);
        #1;
        osel[0] = sel0; ov[0] = valid0; oc[0] = cyc0;
        osel[1] = sel1; ov[1] = valid1; oc[1] = cyc1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) m_starve[m][i] = 0;
                m_rr[m]    = 0;
                m_stall[m] = 0;
                es[m]      = '1;
            end else begin
                denied = req & ~eg[m];
                for (int i = 0; i < 8; i++) begin
                    if (denied[i] && !sq)
                        m_starve[m][i] = (m_starve[m][i] == smax(m)) ? smax(m) : m_starve[m][i] + 1;
                    else
                        m_starve[m][i] = 0;
                end
                m_rr[m] = nrr[m];
                if (!sq && denied != 8'h00 && m_stall[m] < 65535) m_stall[m]++;
            end
            for (int s = 0; s < 3; s++) ev[m][s] = (es[m][s*4 +: 4] != 4'hF);
            chk($sformatf("slot_sel_u%0d", m), osel[m], es[m]);
            chk($sformatf("slot_valid_u%0d", m), ov[m], ev[m]);
            chk($sformatf("stall_cycles_u%0d", m), oc[m], m_stall[m]);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        rsq, rrs;

        // reset state
        step(8'h00, 1'b0, 1'b1, 9'h000);
        chk("reset_sel", sel0, 12'hFFF);
        chk("reset_valid", valid0, 3'b000);
        chk("reset_stall_cycles", cyc0, 16'd0);

        // two requesters fit: both granted, slots {0,2,F}
        step(8'h05, 1'b0, 1'b0, 9'h105);
        chk("case1_sel", sel0, 12'h02F);
        chk("case1_valid", valid0, 3'b110);

        // all requesting from reset: rotating groups of three
        step(8'h00, 1'b0, 1'b1, 9'h000);
        step(8'hFF, 1'b0, 1'b0, 9'h107);
        step(8'hFF, 1'b0, 1'b0, 9'h138);
        step(8'hFF, 1'b0, 1'b0, 9'h1C1);
        step(8'hFF, 1'b0, 1'b0, 9'h10E);
        chk("case2_stall_cycles", cyc0, 16'd4);

        // pointer wrap 6,7,0 then pointer at 1
        step(8'h00, 1'b0, 1'b1, 9'h000);
        step(8'h38, 1'b0, 1'b0, 9'h138);
        step(8'hC1, 1'b0, 1'b0, 9'h1C1);
        chk("case3_sel", sel0, 12'h670);
        step(8'h03, 1'b0, 1'b0, 9'h103);
        chk("case3_rr_sel", sel0, 12'h10F);

        // squash kills grants, empties slots
        step(8'hFF, 1'b0, 1'b0, 9'h000);
        step(8'hFF, 1'b1, 1'b0, 9'h100);
        chk("case5_valid", valid0, 3'b000);
        chk("case5_sel", sel0, 12'hFFF);

        // urgent requester takes slot 2 (STARVE_MAX=1 instance)
        step(8'h00, 1'b0, 1'b1, 9'h000);
        step(8'h0F, 1'b0, 1'b0, 9'h107);
        step(8'hFF, 1'b0, 1'b0, 9'h000);
        chk("case4_urgent_sel", sel1, 12'h345);

        // more than three urgent: lowest three win
        step(8'h00, 1'b0, 1'b1, 9'h000);
        step(8'hFF, 1'b0, 1'b0, 9'h107);
        step(8'hFF, 1'b0, 1'b0, 9'h000);
        chk("many_urgent_sel_a", sel1, 12'h345);
        step(8'hFF, 1'b0, 1'b0, 9'h000);
        chk("many_urgent_sel_b", sel1, 12'h012);

        // reset mid-operation overrides requests
        step(8'hFF, 1'b0, 1'b0, 9'h000);
        step(8'hFF, 1'b0, 1'b1, 9'h000);
        chk("case6_sel", sel0, 12'hFFF);
        chk("case6_valid", valid0, 3'b000);
        chk("case6_stall_cycles", cyc0, 16'd0);
        step(8'hFF, 1'b0, 1'b0, 9'h107);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 1) == 1) ? ($urandom | $urandom) : $urandom;
            rsq = ($urandom_range(0, 7) == 0);
            rrs = ($urandom_range(0, 63) == 0);
            step(r[7:0], rsq, rrs, 9'h000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
